// File: rtl/updown_counter_sequencer.sv
// Step/direction sequencer for the 2-bit up/down counter: conditions raw buttons and switches and
// issues single-cycle step enables in manual, free-run or N-step burst mode.
module updown_counter_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned TICK_CYCLES     = 50_000_000
) (
  input  logic       cp,
  input  logic       rst_n,
  input  logic       btn_step,
  input  logic       btn_run,
  input  logic       sw_dir,
  input  logic [1:0] sw_mode,
  input  logic [3:0] sw_count,
  output logic       step_en,
  output logic       dir,
  output logic       busy,
  output logic       done,
  output logic [1:0] state,
  output logic [3:0] remaining
);

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned TK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned IN_W = 9;
  localparam int unsigned N_BTN = 2;
  localparam int unsigned BTN_STEP = 0;
  localparam int unsigned BTN_RUN  = 1;

  localparam logic [1:0] MODE_MANUAL = 2'b00;
  localparam logic [1:0] MODE_RUN    = 2'b01;
  localparam logic [1:0] MODE_BURST  = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_BURST = 2'b10
  } state_e;

  // Input synchroniser chain: {sw_count, sw_mode, sw_dir, btn_run, btn_step}
  logic [IN_W-1:0] in_meta_q, in_meta_d;
  logic [IN_W-1:0] in_sync_q, in_sync_d;

  logic [DB_W-1:0]  db_cnt_q [N_BTN];
  logic [DB_W-1:0]  db_cnt_d [N_BTN];
  logic [N_BTN-1:0] deb_q, deb_d;
  logic [N_BTN-1:0] deb_prev_q, deb_prev_d;

  logic [TK_W-1:0] tick_cnt_q, tick_cnt_d;

  state_e     state_q, state_d;
  logic       step_en_q, step_en_d;
  logic       dir_q, dir_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [3:0] remaining_q, remaining_d;

  logic [N_BTN-1:0] btn_sync;
  logic [N_BTN-1:0] press;
  logic             sw_dir_s;
  logic [1:0]       sw_mode_s;
  logic [3:0]       sw_count_s;
  logic             tick;

  // Synchronisers and per-button debounce with rising-edge press detect
  always_comb begin
    in_meta_d  = {sw_count, sw_mode, sw_dir, btn_run, btn_step};
    in_sync_d  = in_meta_q;
    btn_sync   = in_sync_q[1:0];
    sw_dir_s   = in_sync_q[2];
    sw_mode_s  = in_sync_q[4:3];
    sw_count_s = in_sync_q[8:5];

    deb_d      = deb_q;
    deb_prev_d = deb_q;
    for (int i = 0; i < N_BTN; i++) begin
      db_cnt_d[i] = '0;
      if (btn_sync[i] != deb_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          deb_d[i] = btn_sync[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
    press = deb_q & ~deb_prev_q;
  end

  // Step-rate divider; parked at zero while idle so the first step lands a full period in
  always_comb begin
    tick = (tick_cnt_q == TK_W'(TICK_CYCLES - 1));
    if (state_q == S_IDLE || tick) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + TK_W'(1);
    end
  end

  // Mode sequencer next-state and registered-output values
  always_comb begin
    state_d     = state_q;
    step_en_d   = 1'b0;
    done_d      = 1'b0;
    dir_d       = dir_q;
    remaining_d = remaining_q;

    case (state_q)
      S_IDLE: begin
        remaining_d = 4'd0;
        case (sw_mode_s)
          MODE_MANUAL: begin
            if (press[BTN_STEP]) begin
              step_en_d = 1'b1;
              dir_d     = sw_dir_s;
            end
          end
          MODE_RUN: begin
            if (press[BTN_RUN]) state_d = S_RUN;
          end
          MODE_BURST: begin
            if (press[BTN_RUN] && sw_count_s != 4'd0) begin
              state_d     = S_BURST;
              remaining_d = sw_count_s;
              dir_d       = sw_dir_s;
            end
          end
          default: ;
        endcase
      end

      S_RUN: begin
        if (sw_mode_s != MODE_RUN || press[BTN_RUN]) begin
          state_d = S_IDLE;
        end else if (tick) begin
          step_en_d = 1'b1;
          dir_d     = sw_dir_s;
        end
      end

      S_BURST: begin
        // Abort wins over a coincident tick
        if (sw_mode_s == MODE_HOLD || press[BTN_RUN]) begin
          state_d     = S_IDLE;
          remaining_d = 4'd0;
        end else if (remaining_q == 4'd0) begin
          state_d = S_IDLE;
        end else if (tick) begin
          step_en_d   = 1'b1;
          remaining_d = remaining_q - 4'd1;
          if (remaining_q == 4'd1) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d     = S_IDLE;
        remaining_d = 4'd0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge cp) begin
    if (!rst_n) begin
      in_meta_q   <= '0;
      in_sync_q   <= '0;
      for (int i = 0; i < N_BTN; i++) db_cnt_q[i] <= '0;
      deb_q       <= '0;
      deb_prev_q  <= '0;
      tick_cnt_q  <= '0;
      state_q     <= S_IDLE;
      step_en_q   <= 1'b0;
      dir_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      remaining_q <= 4'd0;
    end else begin
      in_meta_q   <= in_meta_d;
      in_sync_q   <= in_sync_d;
      for (int i = 0; i < N_BTN; i++) db_cnt_q[i] <= db_cnt_d[i];
      deb_q       <= deb_d;
      deb_prev_q  <= deb_prev_d;
      tick_cnt_q  <= tick_cnt_d;
      state_q     <= state_d;
      step_en_q   <= step_en_d;
      dir_q       <= dir_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      remaining_q <= remaining_d;
    end
  end

  assign step_en   = step_en_q;
  assign dir       = dir_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign state     = state_q;
  assign remaining = remaining_q;

endmodule

// File: tb/tb_updown_counter_sequencer.sv
// Scoreboard bench for updown_counter_sequencer: expected step events are queued when stimulus is
// applied and matched against every step_en pulse the DUT produces.
module tb_updown_counter_sequencer;

  localparam int unsigned DEB  = 4;
  localparam int unsigned TICK = 8;

  logic       cp = 1'b0;
  logic       rst_n;
  logic       btn_step, btn_run, sw_dir;
  logic [1:0] sw_mode;
  logic [3:0] sw_count;
  logic       step_en, dir, busy, done;
  logic [1:0] state;
  logic [3:0] remaining;

  typedef struct {
    int         cyc;
    logic       dir;
    logic       done;
    logic [3:0] rem;
    logic [1:0] st;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  updown_counter_sequencer #(
    .DEBOUNCE_CYCLES(DEB),
    .TICK_CYCLES    (TICK)
  ) dut (
    .cp       (cp),
    .rst_n    (rst_n),
    .btn_step (btn_step),
    .btn_run  (btn_run),
    .sw_dir   (sw_dir),
    .sw_mode  (sw_mode),
    .sw_count (sw_count),
    .step_en  (step_en),
    .dir      (dir),
    .busy     (busy),
    .done     (done),
    .state    (state),
    .remaining(remaining)
  );

  always #5 cp = ~cp;
  always @(posedge cp) cyc++;

  task automatic check_val(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) begin
      @(posedge cp);
      #1;
    end
  endtask

  task automatic push_step(input int c, input logic d, input logic dn, input logic [3:0] r,
                           input logic [1:0] s);
    exp_t e;
    e.cyc = c; e.dir = d; e.done = dn; e.rem = r; e.st = s;
    exp_q.push_back(e);
  endtask

  // Output monitor: every step pulse must match the head of the queue
  always @(negedge cp) begin
    exp_t e;
    if (step_en) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_step", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check_val("step_cycle", cyc, e.cyc);
        check_val("step_dir", int'(dir), int'(e.dir));
        check_val("step_done", int'(done), int'(e.done));
        check_val("step_remaining", int'(remaining), int'(e.rem));
        check_val("step_state", int'(state), int'(e.st));
      end
    end else begin
      if (done) check_val("done_without_step", 1, 0);
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        check_val("step_missed", cyc, e.cyc);
      end
    end
  end

  initial begin
    int n;
    rst_n = 1'b0; btn_step = 1'b0; btn_run = 1'b0; sw_dir = 1'b0;
    sw_mode = 2'b00; sw_count = 4'd0;

    // Reset with buttons toggling
    for (int i = 0; i < 3; i++) begin
      @(posedge cp); #1;
      btn_step = ~btn_step;
      btn_run  = ~btn_run;
    end
    check_val("rst_state", int'(state), 0);
    check_val("rst_step_en", int'(step_en), 0);
    check_val("rst_dir", int'(dir), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_done", int'(done), 0);
    check_val("rst_remaining", int'(remaining), 0);
    btn_step = 1'b0; btn_run = 1'b0;
    rst_n = 1'b1;
    wait_to(cyc + 12);

    // Manual: glitch ignored, stable press gives exactly one step
    sw_mode = 2'b00; sw_dir = 1'b1;
    wait_to(cyc + 3);
    btn_step = 1'b1;
    wait_to(cyc + 2);
    btn_step = 1'b0;
    wait_to(cyc + 12);
    n = cyc;
    btn_step = 1'b1;
    push_step(n + 7, 1'b1, 1'b0, 4'd0, 2'b00);
    wait_to(n + 25);
    btn_step = 1'b0;
    wait_to(n + 35);

    // Free-run, live direction change, abort press landing on a tick
    sw_mode = 2'b01; sw_dir = 1'b0;
    wait_to(cyc + 3);
    n = cyc;
    btn_run = 1'b1;
    push_step(n + 15, 1'b0, 1'b0, 4'd0, 2'b01);
    push_step(n + 23, 1'b0, 1'b0, 4'd0, 2'b01);
    wait_to(n + 8);
    check_val("run_busy", int'(busy), 1);
    check_val("run_state", int'(state), 1);
    wait_to(n + 10);
    btn_run = 1'b0;
    wait_to(n + 24);
    sw_dir = 1'b1;
    push_step(n + 31, 1'b1, 1'b0, 4'd0, 2'b01);
    wait_to(n + 32);
    btn_run = 1'b1;
    wait_to(n + 40);
    check_val("run_stop_state", int'(state), 0);
    check_val("run_stop_busy", int'(busy), 0);
    btn_run = 1'b0;
    wait_to(n + 60);

    // Burst of 3; switch changes during the burst are ignored
    sw_mode = 2'b10; sw_count = 4'd3; sw_dir = 1'b1;
    wait_to(cyc + 3);
    n = cyc;
    btn_run = 1'b1;
    push_step(n + 15, 1'b1, 1'b0, 4'd2, 2'b10);
    push_step(n + 23, 1'b1, 1'b0, 4'd1, 2'b10);
    push_step(n + 31, 1'b1, 1'b1, 4'd0, 2'b00);
    wait_to(n + 8);
    check_val("burst_remaining_start", int'(remaining), 3);
    check_val("burst_busy", int'(busy), 1);
    check_val("burst_state", int'(state), 2);
    wait_to(n + 10);
    btn_run = 1'b0;
    wait_to(n + 12);
    sw_dir = 1'b0; sw_count = 4'd7; sw_mode = 2'b00;
    wait_to(n + 32);
    check_val("burst_end_state", int'(state), 0);
    check_val("burst_end_busy", int'(busy), 0);
    check_val("burst_end_remaining", int'(remaining), 0);
    wait_to(n + 40);

    // Burst length 0: run press ignored
    sw_mode = 2'b10; sw_count = 4'd0;
    wait_to(cyc + 3);
    btn_run = 1'b1;
    wait_to(cyc + 10);
    check_val("zero_count_busy", int'(busy), 0);
    btn_run = 1'b0;
    wait_to(cyc + 10);
    check_val("zero_count_state", int'(state), 0);

    // Burst of 5 aborted by hold mode after two steps
    sw_count = 4'd5; sw_dir = 1'b0; sw_mode = 2'b10;
    wait_to(cyc + 3);
    n = cyc;
    btn_run = 1'b1;
    push_step(n + 15, 1'b0, 1'b0, 4'd4, 2'b10);
    push_step(n + 23, 1'b0, 1'b0, 4'd3, 2'b10);
    wait_to(n + 10);
    btn_run = 1'b0;
    wait_to(n + 24);
    sw_mode = 2'b11;
    wait_to(n + 26);
    check_val("hold_pre_state", int'(state), 2);
    wait_to(n + 27);
    check_val("hold_state", int'(state), 0);
    check_val("hold_remaining", int'(remaining), 0);
    check_val("hold_busy", int'(busy), 0);
    wait_to(n + 45);

    // Run press coinciding with a burst tick aborts without stepping
    sw_mode = 2'b10;
    wait_to(cyc + 3);
    n = cyc;
    btn_run = 1'b1;
    push_step(n + 15, 1'b0, 1'b0, 4'd4, 2'b10);
    wait_to(n + 8);
    btn_run = 1'b0;
    wait_to(n + 16);
    btn_run = 1'b1;
    wait_to(n + 22);
    check_val("tick_abort_pre_state", int'(state), 2);
    wait_to(n + 23);
    check_val("tick_abort_state", int'(state), 0);
    check_val("tick_abort_remaining", int'(remaining), 0);
    wait_to(n + 30);
    btn_run = 1'b0;
    wait_to(n + 45);

    // Reset in the middle of a burst
    sw_count = 4'd3; sw_dir = 1'b1;
    wait_to(cyc + 3);
    n = cyc;
    btn_run = 1'b1;
    push_step(n + 15, 1'b1, 1'b0, 4'd2, 2'b10);
    wait_to(n + 10);
    btn_run = 1'b0;
    wait_to(n + 17);
    rst_n = 1'b0;
    wait_to(n + 19);
    check_val("midrst_remaining", int'(remaining), 0);
    check_val("midrst_busy", int'(busy), 0);
    check_val("midrst_state", int'(state), 0);
    rst_n = 1'b1;
    wait_to(n + 60);
    check_val("midrst_busy_after", int'(busy), 0);

    check_val("pending_steps", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
